// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus start sequencer feeding a UART transmitter.
// Issues one tx_start per byte when the transmitter is idle, then waits out a baud-tick guard.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a queued byte and an idle transmitter
// S_START | tx_start high for this single cycle
// S_BUSY  | transmitter is shifting the frame out
// S_GAP   | counting GAP_TICKS baud ticks to guarantee a full stop bit
module uart_tx_feeder #(
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     flush,
  input  logic                     baud_tick,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     idle
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] gap_cnt;
  logic          wr_en, pop, gap_inc;

  assign wr_ready   = (count != CW'(DEPTH));
  assign wr_en      = wr_valid && wr_ready && !flush;
  assign fifo_count = count;
  assign idle       = (count == '0) && (state == S_IDLE) && !tx_busy;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    gap_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if ((count != '0) && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: state_nxt = S_BUSY;
      S_BUSY: begin
        if (!tx_busy) begin
          if (GAP_TICKS > 0) state_nxt = S_GAP;
          else               state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (baud_tick) begin
          if (gap_cnt == GW'(GAP_LAST)) state_nxt = S_IDLE;
          else                          gap_inc   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Guard counter only runs inside S_GAP, so leaving any other state clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state != S_GAP) begin
      gap_cnt <= '0;
    end else if (gap_inc) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A byte popped in the same cycle as a flush still goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: transmitter model, baud strobe, and a
// queue-based scoreboard of bytes accepted but not yet started.
module tb_uart_tx_feeder;
  localparam int DEPTH     = 16;
  localparam int GAP_TICKS = 1;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_valid = 1'b0;
  logic          flush = 1'b0;
  logic          baud_tick = 1'b0;
  logic          model_busy = 1'b0;
  logic          hold_busy = 1'b0;
  logic          tx_busy;
  logic          wr_ready, tx_start, idle;
  logic [7:0]    tx_data;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int start_count = 0;
  int pushed = 0;
  int ticks = 100;
  int busy_len = 30;
  int cyc = 0;
  int bcnt = 0;
  logic xs;
  logic prev_start = 1'b0, prev_busy = 1'b0;
  logic [7:0] mon_e;

  assign tx_busy = model_busy | hold_busy;

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP_TICKS(GAP_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .flush(flush), .baud_tick(baud_tick), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count), .idle(idle)
  );

  always #5 clk = ~clk;

  // Transmitter: samples tx_start at the edge closing the START cycle, busy for busy_len cycles.
  always begin
    @(posedge clk);
    xs = tx_start;
    #1;
    if (xs) begin
      model_busy = 1'b1;
      bcnt = busy_len;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) model_busy = 1'b0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    cyc++;
    baud_tick = (cyc % 4 == 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        start_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start tx_data=%02h but no byte pending", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          checks++;
          if (tx_data !== mon_e) begin
            errors++;
            $display("FAIL tx_data_order got %02h expected %02h", tx_data, mon_e);
          end
        end
        checks++;
        if (prev_start) begin errors++; $display("FAIL start_spacing got back-to-back tx_start expected gap"); end
        checks++;
        if (tx_busy) begin errors++; $display("FAIL start_while_busy got tx_busy=1 expected 0"); end
        checks++;
        if (ticks < GAP_TICKS) begin
          errors++;
          $display("FAIL guard_gap got %0d ticks expected >= %0d", ticks, GAP_TICKS);
        end
      end
      checks++;
      if (fifo_count !== CW'(exp_q.size())) begin
        errors++;
        $display("FAIL fifo_count got %0d expected %0d", fifo_count, exp_q.size());
      end
      checks++;
      if (wr_ready !== (exp_q.size() != DEPTH)) begin
        errors++;
        $display("FAIL wr_ready got %0b expected %0b", wr_ready, exp_q.size() != DEPTH);
      end
    end
    if (model_busy) ticks = 0;
    else if (!prev_busy && baud_tick) ticks++;
    prev_start = tx_start;
    prev_busy  = model_busy;
  end

  task automatic do_write(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(posedge clk);
    if (exp_q.size() < DEPTH && !flush) begin
      exp_q.push_back(b);
      pushed++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && idle) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #23;
    checks++; if (tx_start !== 1'b0)     begin errors++; $display("FAIL reset_tx_start got %0b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00)     begin errors++; $display("FAIL reset_tx_data got %02h expected 00", tx_data); end
    checks++; if (fifo_count !== '0)     begin errors++; $display("FAIL reset_fifo_count got %0d expected 0", fifo_count); end
    checks++; if (wr_ready !== 1'b1)     begin errors++; $display("FAIL reset_wr_ready got %0b expected 1", wr_ready); end
    checks++; if (idle !== 1'b1)         begin errors++; $display("FAIL reset_idle got %0b expected 1", idle); end
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    bit ok;
    #1;
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL single_count0 got %0d expected 0", fifo_count); end
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    @(posedge clk);
    exp_q.push_back(8'hA5);
    pushed++;
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL single_count1 got %0d expected 1", fifo_count); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start got %0b expected 0", tx_start); end
    @(negedge clk); #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %0b expected 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %02h expected a5", tx_data); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL single_count2 got %0d expected 0", fifo_count); end
    @(negedge clk); #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %0b expected 0", tx_start); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %0b expected 0", idle); end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (idle) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_idle_timeout got idle=0 expected 1"); end
    checks++;
    if (model_busy || ticks < GAP_TICKS) begin
      errors++;
      $display("FAIL single_idle_early got busy=%0b ticks=%0d expected busy=0 ticks>=%0d", model_busy, ticks, GAP_TICKS);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int s0;
    s0 = start_count;
    do_write(8'h11);
    do_write(8'h22);
    do_write(8'h33);
    wait_drain(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain got timeout expected drained"); end
    checks++; if (start_count - s0 != 3) begin errors++; $display("FAIL b2b_starts got %0d expected 3", start_count - s0); end
  endtask

  task automatic test_full_wrap;
    bit ok;
    int s0, n0;
    s0 = start_count;
    n0 = pushed;
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) do_write(8'($urandom));
    #1;
    checks++; if (pushed - n0 != 16) begin errors++; $display("FAIL full_accepted got %0d expected 16", pushed - n0); end
    checks++; if (fifo_count !== CW'(16)) begin errors++; $display("FAIL full_count got %0d expected 16", fifo_count); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %0b expected 0", wr_ready); end
    hold_busy = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() <= 12) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain_start got timeout expected drain"); end
    for (int i = 0; i < 4; i++) do_write(8'($urandom));
    wait_drain(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain got timeout expected drained"); end
    checks++; if (start_count - s0 != 20) begin errors++; $display("FAIL wrap_starts got %0d expected 20", start_count - s0); end
  endtask

  task automatic test_flush;
    bit ok;
    int s0;
    for (int i = 0; i < 5; i++) do_write(8'h40 + 8'(i));
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (model_busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL flush_busy_timeout got busy=0 expected 1"); end
    flush = 1'b1;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk); #1;
    flush = 1'b0;
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL flush_count got %0d expected 0", fifo_count); end
    s0 = start_count;
    repeat (120) @(negedge clk);
    #1;
    checks++; if (start_count != s0) begin errors++; $display("FAIL flush_no_start got %0d starts expected 0", start_count - s0); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle got %0b expected 1", idle); end
    do_write(8'h5A);
    wait_drain(300, ok);
    checks++; if (!ok || start_count != s0 + 1) begin errors++; $display("FAIL flush_restart got %0d starts expected 1", start_count - s0); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int s0;
    for (int i = 0; i < 4; i++) do_write(8'h81 + 8'(i));
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (model_busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_busy_timeout got busy=0 expected 1"); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0)  begin errors++; $display("FAIL rstmid_tx_start got %0b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL rstmid_tx_data got %02h expected 00", tx_data); end
    checks++; if (fifo_count !== '0)  begin errors++; $display("FAIL rstmid_count got %0d expected 0", fifo_count); end
    checks++; if (wr_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_wr_ready got %0b expected 1", wr_ready); end
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    s0 = start_count;
    repeat (80) @(negedge clk);
    #1;
    checks++; if (start_count != s0) begin errors++; $display("FAIL rstmid_no_start got %0d starts expected 0", start_count - s0); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle got %0b expected 1", idle); end
    do_write(8'h77);
    wait_drain(300, ok);
    checks++; if (!ok || start_count != s0 + 1) begin errors++; $display("FAIL rstmid_restart got %0d starts expected 1", start_count - s0); end
  endtask

  task automatic test_write_at_pop;
    bit ok;
    int s0;
    s0 = start_count;
    do_write(8'hC1);
    do_write(8'hC2);
    #1;
    checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL pop_write_count got %0d expected 1", fifo_count); end
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'hC1) begin
      errors++; $display("FAIL pop_write_start got start=%0b data=%02h expected 1/c1", tx_start, tx_data);
    end
    wait_drain(300, ok);
    checks++; if (!ok || start_count - s0 != 2) begin errors++; $display("FAIL pop_write_drain got %0d starts expected 2", start_count - s0); end
  endtask

  task automatic test_random;
    bit ok;
    int s0, n0;
    s0 = start_count;
    n0 = pushed;
    for (int i = 0; i < 200; i++) begin
      busy_len = $urandom_range(20, 2);
      if ($urandom_range(2, 0) == 0) do_write(8'($urandom));
      else @(negedge clk);
    end
    wait_drain(5000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL random_drain got timeout expected drained"); end
    checks++; if (start_count - s0 != pushed - n0) begin
      errors++; $display("FAIL random_starts got %0d expected %0d", start_count - s0, pushed - n0);
    end
    busy_len = 30;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_wrap();
    test_flush();
    test_reset_mid();
    test_write_at_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte FIFO and start sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the system side over a valid/ready handshake and buffers them in DEPTH entries. It then issues one-cycle `tx_start` pulses with the byte on `tx_data`, one at a time, whenever the transmitter is idle. A programmable guard of GAP_TICKS baud ticks after each frame guarantees a full stop bit before the next start bit.

## Interface
- DEPTH, 16, FIFO entries; power of two, minimum 2
- GAP_TICKS, 1, baud ticks to wait after `tx_busy` falls before the next `tx_start`; 0 disables the guard
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_data  in  8  byte to enqueue
- wr_valid  in  1  `wr_data` is valid this cycle
- wr_ready  out  1  FIFO can accept a byte; equals (count != DEPTH)
- flush  in  1  synchronous FIFO clear
- baud_tick  in  1  one-cycle baud strobe, same strobe the transmitter uses
- tx_busy  in  1  transmitter busy, from the transmitter
- tx_start  out  1  one-cycle start request to the transmitter (registered)
- tx_data  out  8  byte for the transmitter; held stable from the `tx_start` cycle until the next `tx_start` (registered)
- fifo_count  out  $clog2(DEPTH)+1  bytes currently queued
- idle  out  1  high when count==0, FSM in IDLE, and `tx_busy`==0

## Operation
- **Storage:**
  - DEPTH x 8 register array.
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - `count` is tracked separately.
- **Write:** accepted when `wr_valid` && `wr_ready`. `mem[wr_ptr]` <= `wr_data`, `wr_ptr`++.
- **Pop:** occurs on the IDLE->START transition. `tx_data` <= `mem[rd_ptr]`, `rd_ptr`++.
- **Count update:** write only: +1. Pop only: -1. Write and pop in the same cycle: unchanged.
- **`wr_ready`:** depends only on `count`, never combinationally on a same-cycle pop. When full, a write is refused even if a pop happens that cycle.
- **FSM states:** IDLE, START, BUSY, GAP.
  - IDLE: if count != 0 && !`tx_busy`, pop and go to START.
  - START: `tx_start`=1 for exactly this cycle. Next state is BUSY unconditionally.
  - BUSY: wait for `tx_busy`==0. A compliant transmitter raises busy in the first BUSY cycle, so BUSY never exits early. On `tx_busy`==0, go to GAP if GAP_TICKS>0, else IDLE.
  - GAP: count `baud_tick` pulses. Go to IDLE on the cycle the GAP_TICKS-th tick is seen. The counter is cleared on entry.
- **flush:** `wr_ptr`, `rd_ptr` and `count` are cleared at the next edge.
  - A write in the same cycle is discarded.
  - flush wins over a simultaneous pop's count update.
  - A byte already popped (START/BUSY/GAP) still completes normally.
  - No further `tx_start` is issued until new data is written.
- **Reset (async, any time, including mid-frame):**
  - FSM returns to IDLE.
  - `tx_start`=0, `tx_data`=0x00, `fifo_count`=0.
  - Pointers and GAP counter are cleared.
  - `wr_ready`=1 and `idle`=1 (given `tx_busy`=0).
  - Queued bytes are lost.
  - Memory contents need no reset.

## Timing
- **Write-to-start latency (empty FIFO, transmitter idle, FSM in IDLE):**
  - Write accepted at edge N.
  - `fifo_count`=1 in cycle N+1.
  - IDLE->START at edge N+1, so `tx_start`=1 and `tx_data` are valid in cycle N+2.
  - `fifo_count` returns to 0 in cycle N+2.
- **Transmitter acceptance:** the transmitter samples `tx_start` at the end of the START cycle and shows `tx_busy`=1 in the first BUSY cycle.
- **Back-to-back bytes:**
  - Next `tx_start` comes no earlier than (edge where `tx_busy` is seen 0) + GAP_TICKS `baud_tick` pulses + 1 cycle.
  - With GAP_TICKS=0: `tx_start` occurs 2 cycles after `tx_busy` first reads 0 (BUSY->IDLE, then IDLE->START).
- **Spacing:** `tx_start` is never high in two consecutive cycles and never high while `tx_busy`=1.
- **Status outputs:** `fifo_count`, `wr_ready` and `idle` update one cycle after the causing edge (from registered state).

## Test plan
- Reset, then write 0xA5 at edge N (GAP_TICKS=1, transmitter model busy 30 cycles) -> `tx_start`=1 for one cycle at N+2 with `tx_data`=0xA5; `fifo_count` sequence 0,1,0; `idle`=1 after `tx_busy` falls and one `baud_tick`.
- Write 0x11, 0x22, 0x33 back-to-back -> three `tx_start` pulses carrying 0x11, 0x22, 0x33 in order; each occurs only after `tx_busy` falls plus one `baud_tick`; never during busy.
- Hold `tx_busy`=1 and write 17 bytes (DEPTH=16) -> `wr_ready`=0 after the 16th; 17th not accepted; `fifo_count`=16. Release busy, then write 4 more during drain (pointer wrap) -> all 20 accepted bytes transmitted in order.
- 5 bytes queued, flush asserted one cycle during BUSY -> `fifo_count`=0 next cycle; current frame completes; no further `tx_start`; a write afterwards starts normally.
- 4 bytes queued, `rst_n` pulled low mid-BUSY -> immediately `tx_start`=0, `tx_data`=0x00, `fifo_count`=0, `wr_ready`=1; no `tx_start` after release until new writes.
- `fifo_count`=1 in IDLE with `wr_valid`=1 on the same edge as the pop -> `fifo_count` stays 1; the written byte is the next transmitted.
